wallace_final_cpa: RTL and testbench

- Multi-cycle carry-propagate adder that sits directly downstream of the partial-product accumulator tree.
- Consumes the redundant sum/carry vector pair from the tree and resolves it into one binary product word.
- Adds CHUNK bits per cycle, so no full-width ripple path exists, and the multiplier top can close timing at higher clock rates.
- Valid/ready handshake on both the input and output sides.

---
 rtl/wallace_final_cpa.sv | 93 +++++++++
 tb/tb_wallace_final_cpa.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wallace_final_cpa.sv
// Multi-cycle final carry-propagate adder for the multiplier tree: resolves the redundant
// sum/carry pair CHUNK bits per cycle behind a valid/ready handshake on both sides.
module wallace_final_cpa #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             carry_out
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % CHUNK != 0) begin : gen_bad_cfg
    $error("wallace_final_cpa: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q;
  logic [WIDTH-1:0]  s_q;
  logic [WIDTH-1:0]  c_q;
  logic [WIDTH-1:0]  product_q;
  logic              carry_out_q;
  logic              out_valid_q;
  logic [CHUNK:0]    chunk_sum;
  logic              last_chunk;

  always_comb begin
    chunk_sum = {1'b0, s_q[cnt_q*CHUNK +: CHUNK]} + {1'b0, c_q[cnt_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (cnt_q == CntW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      product_q   <= '0;
      carry_out_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            s_q     <= s_in;
            c_q     <= c_in;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          product_q[cnt_q*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_q                         <= chunk_sum[CHUNK];
          if (last_chunk) begin
            carry_out_q <= chunk_sum[CHUNK];
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Held low during reset even though the state register already reads IDLE.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_wallace_final_cpa.sv
// Self-checking bench for wallace_final_cpa: directed vector table, backpressure and
// mid-operation reset sequences, then a randomized stall regression against s+c.
module tb_wallace_final_cpa;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s_in;
  logic [31:0] c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        carry_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wallace_final_cpa #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .carry_out (carry_out)
  );

  typedef struct {
    logic [31:0] s;
    logic [31:0] c;
    logic [31:0] p;
    logic        co;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE; returns once out_valid is seen (or the bound expires),
  // leaving out_ready low so the result is still held.
  task automatic run_op(input logic [31:0] s, input logic [31:0] c, output int lat);
    in_valid = 1'b1;
    s_in     = s;
    c_in     = c;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    s_in     = $urandom;
    c_in     = $urandom;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
  endtask

  initial begin
    int          lat;
    logic [31:0] held;
    logic [32:0] exp_q[$];
    logic [32:0] exp_v;
    int          in_cnt;
    int          out_cnt;
    int          cycles;
    logic        fire_in;
    bit          seen;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0};
    vecs[8] = '{32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0};
    vecs[9] = '{32'h0000_FF00, 32'h0000_0100, 32'h0001_0000, 1'b0};

    // Reset held 3 cycles with in_valid asserted.
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    s_in      = 32'hDEAD_BEEF;
    c_in      = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_product", product, 0);
      check("rst_in_ready", in_ready, 0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].s, vecs[i].c, lat);
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_product", i), product, vecs[i].p);
      check($sformatf("vec%0d_carry", i), carry_out, vecs[i].co);
      check($sformatf("vec%0d_in_ready_done", i), in_ready, 0);
      release_out();
      check($sformatf("vec%0d_out_valid_drop", i), out_valid, 0);
      check($sformatf("vec%0d_in_ready_idle", i), in_ready, 1);
    end

    // Output backpressure: result held for 10 cycles, no accept while in DONE.
    run_op(32'h0F0F_0F0F, 32'h0101_0101, lat);
    check("bp_latency", lat, 5);
    held     = product;
    in_valid = 1'b1;
    s_in     = 32'h1;
    c_in     = 32'h1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_product", product, 32'h1010_1010);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check("bp_product_stable", product, held);
    release_out();
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // Reset in the second ADD cycle abandons the operation.
    in_valid = 1'b1;
    s_in     = 32'hFFFF_FFFF;
    c_in     = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", seen, 0);
    run_op(32'h1234_5678, 32'h1111_1111, lat);
    check("midrst_next_latency", lat, 5);
    check("midrst_next_product", product, 32'h2345_6789);
    check("midrst_next_carry", carry_out, 0);
    release_out();

    // Random regression with stalls on both sides.
    in_cnt  = 0;
    out_cnt = 0;
    cycles  = 0;
    fire_in = 1'b0;
    while (out_cnt < 1000 && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      if (fire_in) in_valid = 1'b0;
      if (!in_valid && in_cnt < 1000 && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        s_in     = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
        c_in     = ($urandom_range(7) == 0) ? 32'h0000_0001 : $urandom;
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      fire_in = in_valid && in_ready;
      if (fire_in) begin
        exp_q.push_back({1'b0, s_in} + {1'b0, c_in});
        in_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rand_extra: got %0h want no result", {carry_out, product});
        end else begin
          exp_v = exp_q.pop_front();
          check("rand_result", {carry_out, product}, exp_v);
        end
        out_cnt++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand_out_count", out_cnt, 1000);
    check("rand_in_count", in_cnt, 1000);
    check("rand_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
